// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU selection codes and divider FSM encoding.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by the EX-stage ALU, multiplier and divider.
package cpu_pkg;

    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_MUL    = 5'b00010;
    localparam logic [4:0] ALU_MULH   = 5'b00011;
    localparam logic [4:0] ALU_MULHSU = 5'b00100;
    localparam logic [4:0] ALU_MULHU  = 5'b00101;
    localparam logic [4:0] ALU_AND    = 5'b00110;
    localparam logic [4:0] ALU_OR     = 5'b00111;
    localparam logic [4:0] ALU_XOR    = 5'b01000;
    localparam logic [4:0] ALU_SLL    = 5'b01001;
    localparam logic [4:0] ALU_SRL    = 5'b01010;
    localparam logic [4:0] ALU_SRA    = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_SLT    = 5'b01101;
    localparam logic [4:0] ALU_SLTU   = 5'b01110;
    localparam logic [4:0] ALU_LUI    = 5'b01111;
    localparam logic [4:0] ALU_DIVU   = 5'b10000;
    localparam logic [4:0] ALU_REM    = 5'b10001;
    localparam logic [4:0] ALU_REMU   = 5'b10010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [4:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] sel);
        return (sel == ALU_REM) || (sel == ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, select.
// Latency: combinational. Backpressure: none, the caller sequences iterations.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // A live remainder is always below the divisor, so a shifted value with
    // bit XLEN set can never produce a borrow; diff[XLEN] is a clean sign.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        rem_nxt = shifted[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit, radix-2 restoring; `done` pulses with the result.
// Latency: 33 cycles accept->done; 1 cycle for div-by-0/overflow/|a|<|b| with MDU_DIV_EARLY_OUT_EN.
// Backpressure: `busy` stalls the pipe; `start` ignored unless idle; `flush` aborts.
module mdu_divider
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rem_q, quo_q, divisor_q;
    logic [XLEN-1:0]   rem_nxt, quo_nxt;
    logic              is_rem_q, neg_q_q, neg_r_q;
    logic              busy_q, done_q, busy_d, done_d, res_we;

    logic              accept, sgn, a_neg, b_neg, b_zero, early;
    logic [XLEN-1:0]   a_abs, b_abs, quo_init, rem_init, fixed;

    assign accept = (state_q == IDLE) && start && !flush && is_div_op(alu_sel);
    assign sgn    = is_signed_div(alu_sel);
    assign a_neg  = sgn & op_a[XLEN-1];
    assign b_neg  = sgn & op_b[XLEN-1];
    assign a_abs  = a_neg ? -op_a : op_a;
    assign b_abs  = b_neg ? -op_b : op_b;
    assign b_zero = (op_b == '0);

`ifdef MDU_DIV_EARLY_OUT_EN
    logic ovf;
    assign ovf   = sgn && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign early = b_zero | ovf | (a_abs < b_abs);

    always_comb begin
        quo_init = a_abs;
        rem_init = '0;
        if (b_zero) begin
            quo_init = '1;
            rem_init = a_abs;
        end else if (ovf) begin
            quo_init = a_abs;
            rem_init = '0;
        end else if (a_abs < b_abs) begin
            quo_init = '0;
            rem_init = a_abs;
        end
    end
`else
    assign early    = 1'b0;
    assign quo_init = a_abs;
    assign rem_init = '0;
`endif

    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = early ? FIX : CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        res_we = 1'b0;
        case (state_q)
            IDLE:    busy_d = accept;
            CALC:    busy_d = !flush;
            FIX: begin
                done_d = !flush;
                res_we = !flush;
            end
            default: busy_d = 1'b0;
        endcase
    end

    assign fixed = is_rem_q ? (neg_r_q ? -rem_q : rem_q)
                            : (neg_q_q ? -quo_q : quo_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            is_rem_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result    <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept) begin
                cnt_q     <= '0;
                rem_q     <= rem_init;
                quo_q     <= quo_init;
                divisor_q <= b_abs;
                is_rem_q  <= is_rem_op(alu_sel);
                // Divide-by-zero quotient stays all ones regardless of sign.
                neg_q_q   <= (a_neg ^ b_neg) & !b_zero;
                neg_r_q   <= a_neg;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
            end
            if (res_we) result <= fixed;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Randomized + directed bench for mdu_divider against a plain-arithmetic reference.
module tb_mdu_divider;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  alu_sel = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = '0;

    mdu_divider #(.XLEN(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alu_sel (alu_sel),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        bit is_s = (sel == ALU_DIV) || (sel == ALU_REM);
        bit is_r = (sel == ALU_REM) || (sel == ALU_REMU);
        int sa = a;
        int sb = b;
        if (b == 0) return is_r ? a : 32'hFFFF_FFFF;
        if (is_s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_r ? 32'h0 : 32'h8000_0000;
            return is_r ? 32'(sa % sb) : 32'(sa / sb);
        end
        return is_r ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EARLY_OUT_EN
        bit is_s = (sel == ALU_DIV) || (sel == ALU_REM);
        logic [31:0] aa = (is_s && a[31]) ? 32'(0 - a) : a;
        logic [31:0] bb = (is_s && b[31]) ? 32'(0 - b) : b;
        if (b == 0) return 1;
        if (is_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (aa < bb) return 1;
`endif
        return 33;
    endfunction

    // Issues one op from the current cycle and returns while still in its done cycle.
    task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n = 0;
        alu_sel = sel; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy_after_accept"}, {31'b0, busy}, 32'd1);
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " done_seen"}, {31'b0, done}, 32'd1);
        chk({tag, " latency"}, n, ref_lat(sel, a, b));
        chk({tag, " result"}, result, exp);
        chk({tag, " busy_in_done"}, {31'b0, busy}, 32'd0);
        last_res = exp;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            4: return 32'(0 - $urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] codes [4];
        int ndone;
        codes[0] = ALU_DIV; codes[1] = ALU_DIVU; codes[2] = ALU_REM; codes[3] = ALU_REMU;

        #22;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("div_neg7", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        run_op("rem_neg7", ALU_REM, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_10", ALU_DIVU, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999);
        run_op("remu_10", ALU_REMU, 32'hFFFF_FFFF, 32'd10, 32'h0000_0005);
        run_op("div_by0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0", ALU_REM, 32'd5, 32'd0, 32'h0000_0005);
        run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("div_negby0", ALU_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_negby0", ALU_REM, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
        @(posedge clk); #1;

        // Flush mid-calculation.
        alu_sel = ALU_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush result_held", result, last_res);
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
        chk("flush no_done", ndone, 0);
        run_op("divu_after_flush", ALU_DIVU, 32'd50, 32'd7, 32'h0000_0007);
        @(posedge clk); #1;

        // Non-divide code is ignored.
        alu_sel = ALU_MUL; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mul busy", {31'b0, busy}, 32'd0);
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) ndone++; end
        chk("mul no_activity", ndone, 0);

        // Flush and start together in IDLE: nothing accepted.
        alu_sel = ALU_DIV; op_a = 32'd9; op_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start busy", {31'b0, busy}, 32'd0);

        // Second start while busy is ignored.
        alu_sel = ALU_DIV; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        alu_sel = ALU_REMU; op_a = 32'd9; op_b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                chk("busy_start result", result, 32'd142);
            end
        end
        chk("busy_start one_done", ndone, 1);
        last_res = 32'd142;

        // Asynchronous reset mid-operation.
        alu_sel = ALU_DIV; op_a = 32'h1234_5678; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("midreset busy", {31'b0, busy}, 32'd0);
        chk("midreset done", {31'b0, done}, 32'd0);
        chk("midreset result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("remu_after_reset", ALU_REMU, 32'd17, 32'd5, 32'h0000_0002);

        // Random back-to-back ops, each started in the previous done cycle.
        for (int i = 0; i < 60; i++) begin
            logic [4:0]  s;
            logic [31:0] a, b;
            s = codes[$urandom_range(0, 3)];
            a = rnd_val();
            b = rnd_val();
            run_op($sformatf("rand%0d", i), s, a, b, ref_res(s, a, b));
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Multi-cycle integer divide unit in the EX stage.
- Consumes the 5-bit ALU selection code from the ALU control unit and executes DIV, DIVU, REM and REMU, which the single-cycle ALU does not handle.
- Holds `busy` high so the hazard unit stalls the pipeline, then returns the result with a one-cycle `done` pulse.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- `XLEN`, default 32: operand and result width.
- `CNT_W`, default 6: width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new operation; sampled only in IDLE.
- `alu_sel`  in  5: ALU selection code, captured with `start`.
- `op_a`  in  XLEN: dividend (rs1), captured with `start`.
- `op_b`  in  XLEN: divisor (rs2), captured with `start`.
- `flush`  in  1: abort the in-flight operation (branch mispredict or exception).
- `busy`  out  1: high from the cycle after accept until `done`.
- `done`  out  1: one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN: quotient or remainder; held until the next accept.

Behaviour:
- Reset (`rst`=0, asynchronous): state=IDLE; `busy`=0, `done`=0, `result`=0; counter, quotient and remainder registers cleared. A reset mid-operation abandons the operation with no `done`.
- Accepted codes:
  - DIV = 5'b01100
  - DIVU = 5'b10000
  - REM = 5'b10001
  - REMU = 5'b10010
- `start` with any other code is ignored: stay in IDLE, `busy` stays 0.
- `start` while `busy`=1 is ignored.
- State machine:
  - IDLE → CALC on edge k, when `start`=1 and the code is accepted. At that edge capture `|op_a|` and `|op_b|` (absolute values only for signed ops), the signed flag, the REM flag, quotient sign = a[31]^b[31], remainder sign = a[31]. Clear the partial remainder; counter=0; `busy`=1.
  - CALC: each edge shifts {rem, quo} left by 1, trial-subtracts the divisor, keeps the difference if it is non-negative, and sets the quotient LSB. Counter increments. After 32 iterations (edges k+1..k+32) → FIX.
  - FIX (edge k+33): negate the quotient or remainder when its sign flag is set and write `result`. Assert `done`=1 and `busy`=0 for one cycle, then → IDLE.
  - Latency is 33 cycles from the accept edge to `done`. A new `start` may be accepted in the `done` cycle.
- Special cases (RISC-V M semantics; without the optional feature they run full latency):
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- `flush`=1 in CALC or FIX → IDLE on the next edge. No `done`; `result` keeps its previous value; `busy`=0.
- `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is accepted.
- `flush` in IDLE has no effect.
- All internal arithmetic is XLEN+1 bits wide to hold the trial-subtract borrow.

Optional Feature:
- Macro: `MDU_DIV_EARLY_OUT_EN`.
- Defined: divisor-zero and signed-overflow cases are detected at accept and go IDLE → FIX directly. `done` arrives 1 cycle after the accept edge, with the values above.
- Also defined: when `|op_a|` < `|op_b|`, the result is produced the same way (quotient 0, remainder = dividend).
- Undefined: every accepted operation takes exactly 33 cycles, with identical results.

Decomposition:
- Shared package `cpu_pkg`:
  - ALU selection localparams (ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, plus the existing ALU/MUL codes).
  - Divider state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
- One sub-module: `mdu_div_step`, the combinational shift/trial-subtract/select for one restoring iteration, instantiated once.

Test Plan:
- DIV a=100, b=0xFFFFFFF9 (-7) → `done` exactly 33 cycles after accept, `result`=0xFFFFFFF2. REM with the same operands → `result`=0x00000002.
- DIVU a=0xFFFFFFFF, b=10 → `result`=0x19999999. REMU with the same operands → `result`=0x00000005.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 0x00000005. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Latency is 1 cycle with `MDU_DIV_EARLY_OUT_EN`, 33 without.
- Start with a DIV, then assert `flush` 10 cycles later → no `done`, `busy`=0 next cycle, `result` unchanged. A following DIVU 50/7 → 0x00000007 after 33 cycles.
- `start` with `alu_sel`=5'b00010 (MUL) → `busy` stays 0, no `done`. A second `start` during an active DIV is ignored; only one `done` occurs.
- Drop `rst` at cycle 20 of a DIV → `busy`, `done` and `result` all 0 immediately. After release, a new REMU 17/5 → 0x00000002.
